// File: rtl/logic_unit_arbiter.sv
// Arbitrates NUM_REQ requesters onto one shared logic unit, one op in flight.
// Define ARB_FIXED_PRIO_EN for fixed lowest-index priority instead of round-robin.
`timescale 1ns/1ps
module logic_unit_arbiter #(
  parameter int NUM_REQ  = 4,
  parameter int WIDTH    = 16,
  parameter int UNIT_LAT = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [2*NUM_REQ-1:0]     req_op,
  input  logic [WIDTH*NUM_REQ-1:0] req_a,
  input  logic [WIDTH*NUM_REQ-1:0] req_b,
  output logic                     unit_start,
  output logic [1:0]               unit_op,
  output logic [WIDTH-1:0]         unit_a,
  output logic [WIDTH-1:0]         unit_b,
  input  logic [WIDTH-1:0]         unit_res,
  output logic [NUM_REQ-1:0]       rsp_valid,
  input  logic [NUM_REQ-1:0]       rsp_ready,
  output logic [WIDTH-1:0]         rsp_data,
  output logic                     busy
);

  localparam int IW = $clog2(NUM_REQ);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [IW-1:0]    r_grant;
  logic [3:0]       r_cnt;
  logic [1:0]       r_op;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_data;
  logic [IW-1:0]    w_win;
  logic             w_any;
  logic             w_acc;
  logic             w_cap;

`ifdef ARB_FIXED_PRIO_EN
  always_comb begin
    w_win = '0;
    w_any = 1'b0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_valid[i]) begin
        w_any = 1'b1;
        w_win = IW'(i);
      end
    end
  end
`else
  logic [IW-1:0] r_ptr;

  // Scan downward so the nearest requester after r_ptr wins.
  always_comb begin
    w_win = '0;
    w_any = 1'b0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      if (req_valid[(int'(r_ptr) + k) % NUM_REQ]) begin
        w_any = 1'b1;
        w_win = IW'((int'(r_ptr) + k) % NUM_REQ);
      end
    end
  end
`endif

  assign w_acc = (r_state == S_IDLE) && w_any;

  assign w_cap = ((r_state == S_ISSUE) && (UNIT_LAT == 1)) ||
                 ((r_state == S_WAIT) && (r_cnt == 4'd1));

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (w_any) w_next = S_ISSUE;
      S_ISSUE: w_next = (UNIT_LAT == 1) ? S_RESP : S_WAIT;
      S_WAIT:  if (r_cnt == 4'd1) w_next = S_RESP;
      S_RESP:  if (rsp_ready[r_grant]) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_grant <= '0;
      r_cnt   <= '0;
      r_op    <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_data  <= '0;
    end else begin
      r_state <= w_next;
      if (w_acc) begin
        r_grant <= w_win;
        r_op    <= req_op[2*int'(w_win) +: 2];
        r_a     <= req_a[int'(w_win)*WIDTH +: WIDTH];
        r_b     <= req_b[int'(w_win)*WIDTH +: WIDTH];
      end
      if (r_state == S_ISSUE) r_cnt <= 4'(UNIT_LAT - 1);
      else if (r_state == S_WAIT) r_cnt <= r_cnt - 4'd1;
      if (w_cap) r_data <= unit_res;
    end
  end

`ifndef ARB_FIXED_PRIO_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_ptr <= IW'(NUM_REQ - 1);
    else if (w_acc) r_ptr <= w_win;
  end
`endif

  assign req_ready  = w_acc ? (NUM_REQ'(1) << w_win) : '0;
  assign unit_start = (r_state == S_ISSUE);
  assign unit_op    = r_op;
  assign unit_a     = r_a;
  assign unit_b     = r_b;
  assign rsp_valid  = (r_state == S_RESP) ? (NUM_REQ'(1) << r_grant) : '0;
  assign rsp_data   = r_data;
  assign busy       = (r_state != S_IDLE);

endmodule

// File: tb/tb_logic_unit_arbiter.sv
// Scoreboard bench: random requesters, behavioural arbiter/unit model.
`timescale 1ns/1ps
module tb_logic_unit_arbiter;
  localparam int N   = 4;
  localparam int W   = 16;
  localparam int LAT = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [N-1:0]   req_valid, req_ready, rsp_valid, rsp_ready;
  logic [2*N-1:0] req_op;
  logic [W*N-1:0] req_a, req_b;
  logic           unit_start, busy;
  logic [1:0]     unit_op;
  logic [W-1:0]   unit_a, unit_b, unit_res, rsp_data;

  logic_unit_arbiter #(.NUM_REQ(N), .WIDTH(W), .UNIT_LAT(LAT)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_a(req_a), .req_b(req_b),
    .unit_start(unit_start), .unit_op(unit_op),
    .unit_a(unit_a), .unit_b(unit_b), .unit_res(unit_res),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .busy(busy)
  );

  typedef struct {
    int         g;
    logic [1:0] op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] res;
    int         acc;
  } txn_t;

  txn_t q[$];
  int n_err = 0;
  int n_chk = 0;
  int cyc = 0;
  int n_acc = 0;
  int n_done = 0;
  int last_hs = -1;
  int ptr = N - 1;
  int ustart = -100;
  bit done = 0;
  bit drained = 0;
  bit abort_miss = 0;

  function automatic logic [W-1:0] gate(input logic [1:0] op,
                                        input logic [W-1:0] a,
                                        input logic [W-1:0] b);
    case (op)
      2'b00:   return a ^ b;
      2'b01:   return a & b;
      2'b10:   return a | b;
      default: return ~a;
    endcase
  endfunction

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Shared unit: result is only correct LAT-1 cycles after the start pulse.
  always @(negedge clk) begin
    if (unit_start) ustart = cyc;
    if (cyc == ustart + LAT - 1) unit_res = gate(unit_op, unit_a, unit_b);
    else unit_res = W'($urandom);
  end

  // Request side: predicts the grant and pushes the expected response.
  always @(negedge clk) begin
    logic [N-1:0] exp_rdy;
    bit fr;
    int w;
    txn_t t;
    if (!rst_n) begin
      chk("rst_req_ready", req_ready, 0);
      chk("rst_busy", busy, 0);
      ptr = N - 1;
      n_acc = 0;
    end else begin
      fr = (n_acc == n_done) && (last_hs != cyc);
      w = -1;
`ifdef ARB_FIXED_PRIO_EN
      for (int i = 0; i < N; i++)
        if (w < 0 && req_valid[i]) w = i;
`else
      for (int k = 1; k <= N; k++)
        if (w < 0 && req_valid[(ptr + k) % N]) w = (ptr + k) % N;
`endif
      exp_rdy = (fr && w >= 0) ? (N'(1) << w) : '0;
      chk("req_ready", req_ready, exp_rdy);
      chk("busy", busy, !fr);
      if (fr && w >= 0) begin
        t.g   = w;
        t.op  = req_op[2*w +: 2];
        t.a   = req_a[w*W +: W];
        t.b   = req_b[w*W +: W];
        t.res = gate(t.op, t.a, t.b);
        t.acc = cyc;
        q.push_back(t);
        n_acc++;
        ptr = w;
      end
    end
  end

  // Response side: pops and compares whenever the DUT should be responding.
  logic [1:0]   last_op = '0;
  logic [W-1:0] last_a = '0;
  logic [W-1:0] last_b = '0;

  always @(negedge clk) begin
    txn_t e;
    bit rv;
    if (!rst_n) begin
      chk("rst_unit_start", unit_start, 0);
      chk("rst_unit_op", unit_op, 0);
      chk("rst_unit_a", unit_a, 0);
      chk("rst_unit_b", unit_b, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_rsp_data", rsp_data, 0);
      q.delete();
      n_done = 0;
      last_hs = -1;
      last_op = '0;
      last_a = '0;
      last_b = '0;
    end else if (q.size() == 0) begin
      chk("idle_rsp_valid", rsp_valid, 0);
      chk("idle_unit_start", unit_start, 0);
      chk("hold_unit_a", unit_a, last_a);
      chk("hold_unit_b", unit_b, last_b);
      chk("hold_unit_op", unit_op, last_op);
    end else begin
      e = q[0];
      chk("unit_start", unit_start, cyc == e.acc + 1);
      if (cyc > e.acc) begin
        chk("unit_op", unit_op, e.op);
        chk("unit_a", unit_a, e.a);
        chk("unit_b", unit_b, e.b);
      end
      rv = (cyc >= e.acc + 1 + LAT);
      chk("rsp_valid", rsp_valid, rv ? (N'(1) << e.g) : '0);
      if (rv) chk("rsp_data", rsp_data, e.res);
      if (rv && rsp_ready[e.g]) begin
        void'(q.pop_front());
        n_done++;
        last_hs = cyc;
        last_op = e.op;
        last_a = e.a;
        last_b = e.b;
      end
    end
    if (done && !drained) begin
      drained = 1;
      chk("drain_q_empty", q.size(), 0);
      chk("abort_setup", abort_miss, 0);
    end
  end

  task automatic new_req(input int i);
    req_valid[i] = 1'b1;
    req_op[2*i +: 2] = 2'($urandom);
    req_a[i*W +: W] = W'($urandom);
    req_b[i*W +: W] = W'($urandom);
  endtask

  task automatic run(input int cycles, input int pnew, input int pdrop,
                     input bit full_rdy);
    logic [N-1:0] acc;
    repeat (cycles) begin
      @(negedge clk);
      acc = req_valid & req_ready;
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) begin
        if (acc[i] || !req_valid[i]) begin
          if ($urandom_range(0, 99) < pnew) new_req(i);
          else req_valid[i] = 1'b0;
        end else if ($urandom_range(0, 99) < pdrop) begin
          req_valid[i] = 1'b0;
        end
      end
      rsp_ready = full_rdy ? '1 : N'($urandom);
    end
  endtask

  initial begin
    bit got;
    req_valid = '0;
    rsp_ready = '0;
    req_op = '0;
    req_a = '0;
    req_b = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    req_valid = 4'b0011;
    req_op[1:0] = 2'b00;
    req_a[15:0] = 16'hF0F0;
    req_b[15:0] = 16'hFF00;
    req_op[3:2] = 2'b01;
    req_a[31:16] = 16'h1234;
    req_b[31:16] = 16'h00FF;
    rsp_ready = '1;
    run(12, 0, 0, 1'b1);
    run(60, 100, 0, 1'b1);
    run(600, 35, 4, 1'b0);
    req_valid = '1;
    rsp_ready = '1;
    got = 0;
    for (int k = 0; k < 60 && !got; k++) begin
      @(negedge clk);
      if (|(req_valid & req_ready)) got = 1;
    end
    if (!got) abort_miss = 1;
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    req_valid = '0;
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) new_req(i);
    rst_n = 1'b1;
    run(300, 40, 3, 1'b0);
    req_valid = '0;
    rsp_ready = '1;
    repeat (20) @(posedge clk);
    done = 1;
    repeat (2) @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
